// File: rtl/arb3s.sv
// -----------------------------------------------------------------------------
// arb3s -- three-source round-robin arbiter that steers a mux3s select.
//
// The arbiter grants one of three requesters at a time and holds that grant
// until the downstream consumer accepts it (valid_o & ready_i) or until the
// granted source withdraws its request. A 2-bit pointer remembers the
// last-served source. Priority always starts at the source after it, so
// continuous requesters are served strictly in turn.
//
// Every output comes straight from a flop. The next-state logic works out the
// next winner, and the output decode turns that winner into the next
// grant/select values. Both are registered on the same edge, so no path runs
// from any input to any output.
//
// Ports
//   VDD, GND  in   1  power pins (only with PWR_PINS), no logic use
//   clk_i     in   1  clock, all state on rising edge
//   rst_i     in   1  asynchronous active-high reset
//   req_i     in   3  per-source request, bit k = source k
//   ready_i   in   1  consumer accepts the current mux output
//   valid_o   out  1  a granted source is on the mux output
//   gnt_o     out  3  one-hot grant, zero when valid_o = 0
//   s_o       out  2  mux3s select: src0 -> 10, src1 -> 11, src2 -> 00
// -----------------------------------------------------------------------------
module arb3s (
`ifdef PWR_PINS
   input  logic       VDD,
   input  logic       GND,
`endif
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] req_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [2:0] gnt_o,
   output logic [1:0] s_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Select code that parks the mux on source 0; also the reset value.
   localparam logic [1:0] SEL_SRC0 = 2'b10;
   localparam logic [1:0] SEL_SRC1 = 2'b11;
   localparam logic [1:0] SEL_SRC2 = 2'b00;

   // Pointer value that makes source 0 the highest priority.
   localparam logic [1:0] PTR_RESET = 2'd2;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] win;
   logic [1:0] win_nxt;
   logic [1:0] ptr;
   logic [1:0] ptr_nxt;
   logic       valid;
   logic       valid_nxt;
   logic [2:0] gnt;
   logic [2:0] gnt_nxt;
   logic [1:0] s;
   logic [1:0] s_nxt;
   logic       win_req;

   // One-hot vector for a source index. Index 3 never occurs, so it decodes
   // to "no source".
   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // Select code for a source index. Code 01 is left out on purpose: an
   // out-of-range index maps to the source 2 code rather than to 01.
   function automatic logic [1:0] sel_code(input logic [1:0] idx);
      logic [1:0] code;
      case (idx)
         2'd0:    code = SEL_SRC0;
         2'd1:    code = SEL_SRC1;
         default: code = SEL_SRC2;
      endcase
      return code;
   endfunction

   // Highest-priority requester when the last-served source is 'last'.
   // The search order is last+1, last+2, last+3 (mod 3). The last-served
   // source therefore comes last, which also lets it be re-granted when it is
   // the only one asking. Callers only use the result when |req is true.
   function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                          input logic [1:0] last);
      logic [1:0] c1;
      logic [1:0] c2;
      logic [1:0] c3;
      logic [1:0] pick;
      case (last)
         2'd0: begin
            c1 = 2'd1;
            c2 = 2'd2;
            c3 = 2'd0;
         end
         2'd1: begin
            c1 = 2'd2;
            c2 = 2'd0;
            c3 = 2'd1;
         end
         default: begin
            c1 = 2'd0;
            c2 = 2'd1;
            c3 = 2'd2;
         end
      endcase
      if (|(req & onehot3(c1))) begin
         pick = c1;
      end else if (|(req & onehot3(c2))) begin
         pick = c2;
      end else begin
         pick = c3;
      end
      return pick;
   endfunction

   // Current winner still holding its request.
   assign win_req = |(req_i & onehot3(win));

   // State, winner, pointer and registered outputs; reset parks on source 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         win   <= 2'd0;
         ptr   <= PTR_RESET;
         valid <= 1'b0;
         gnt   <= 3'b000;
         s     <= SEL_SRC0;
      end else begin
         state <= state_nxt;
         win   <= win_nxt;
         ptr   <= ptr_nxt;
         valid <= valid_nxt;
         gnt   <= gnt_nxt;
         s     <= s_nxt;
      end
   end

   // Next state, next winner and pointer update.
   always_comb begin
      state_nxt = state;
      win_nxt   = win;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (req_i != 3'b000) begin
               state_nxt = GRANT;
               win_nxt   = rr_pick(req_i, ptr);
            end else begin
               state_nxt = IDLE;
            end
         end
         GRANT: begin
            if (ready_i) begin
               // Handshake: the winner becomes the last-served source, and
               // the next winner is picked against that updated pointer in
               // the same cycle, so back-to-back grants have no bubble.
               ptr_nxt = win;
               if (req_i != 3'b000) begin
                  state_nxt = GRANT;
                  win_nxt   = rr_pick(req_i, win);
               end else begin
                  state_nxt = IDLE;
               end
            end else if (win_req) begin
               state_nxt = GRANT;
            end else begin
               // The request was withdrawn without a transfer, so the
               // pointer is not advanced.
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode of the next state, registered on the same edge.
   always_comb begin
      valid_nxt = 1'b0;
      gnt_nxt   = 3'b000;
      s_nxt     = s;
      if (state_nxt == GRANT) begin
         valid_nxt = 1'b1;
         gnt_nxt   = onehot3(win_nxt);
         s_nxt     = sel_code(win_nxt);
      end else begin
         // The select holds its last value while idle.
         valid_nxt = 1'b0;
         gnt_nxt   = 3'b000;
         s_nxt     = s;
      end
   end

   assign valid_o = valid;
   assign gnt_o   = gnt;
   assign s_o     = s;

   arb3s_chk u_chk (
      .clk   (clk_i),
      .rst   (rst_i),
      .valid (valid),
      .gnt   (gnt),
      .s     (s)
   );

endmodule

// -----------------------------------------------------------------------------
// arb3s_chk -- output invariants of arb3s.
//
// Ports
//   clk, rst  in  clock and reset of the arbiter
//   valid     in  registered valid
//   gnt       in  registered one-hot grant
//   s         in  registered mux select
// -----------------------------------------------------------------------------
module arb3s_chk (
   input logic       clk,
   input logic       rst,
   input logic       valid,
   input logic [2:0] gnt,
   input logic [1:0] s
);

   // Select code 01 has no source behind it.
   a_no_sel_01: assert property (@(posedge clk) disable iff (rst)
      s != 2'b01);

   // A valid output carries exactly one grant.
   a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
      valid |-> $onehot(gnt));

   // An idle output carries no grant.
   a_gnt_idle: assert property (@(posedge clk) disable iff (rst)
      !valid |-> (gnt == 3'b000));

endmodule

// File: tb/tb_arb3s.sv
// -----------------------------------------------------------------------------
// tb_arb3s -- self-checking bench for arb3s.
// The reference model keeps the arbiter as plain integers: a busy flag, the
// winner index and the last-served index. It picks winners by scanning
// (last+i)%3 for i = 1..3.
// -----------------------------------------------------------------------------
module tb_arb3s;

   logic       clk;
   logic       rst;
   logic [2:0] req;
   logic       ready;
   logic       valid;
   logic [2:0] gnt;
   logic [1:0] s;

   int checks;
   int errors;

   // reference model state
   bit         m_busy;
   int         m_win;
   int         m_ptr;
   logic [1:0] m_s;
   logic [1:0] s_tab [3];

   arb3s dut (
`ifdef PWR_PINS
      .VDD     (1'b1),
      .GND     (1'b0),
`endif
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .ready_i (ready),
      .valid_o (valid),
      .gnt_o   (gnt),
      .s_o     (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_pick(input logic [2:0] r, input int last);
      for (int i = 1; i <= 3; i++) begin
         int c;
         c = (last + i) % 3;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // behavioural mux3s: 10 -> i[0], 11 -> i[1], 00 -> i[2]
   function automatic logic mux3(input logic [2:0] d, input logic [1:0] sel);
      case (sel)
         2'b10:   return d[0];
         2'b11:   return d[1];
         2'b00:   return d[2];
         default: return 1'bx;
      endcase
   endfunction

   task automatic m_reset();
      m_busy = 1'b0;
      m_win  = 0;
      m_ptr  = 2;
      m_s    = 2'b10;
   endtask

   task automatic m_edge(input logic [2:0] r, input logic rd);
      if (!m_busy) begin
         if (r != 3'b000) begin
            m_win  = m_pick(r, m_ptr);
            m_busy = 1'b1;
            m_s    = s_tab[m_win];
         end
      end else if (rd) begin
         m_ptr = m_win;
         if (r != 3'b000) begin
            m_win = m_pick(r, m_ptr);
            m_s   = s_tab[m_win];
         end else begin
            m_busy = 1'b0;
         end
      end else if (!r[m_win]) begin
         m_busy = 1'b0;
      end
   endtask

   function automatic logic [2:0] m_gnt();
      return m_busy ? (3'b001 << m_win) : 3'b000;
   endfunction

   // drive inputs, take one rising edge, advance the model, settle 1 ns
   task automatic cycle(input logic [2:0] r, input logic rd);
      req   = r;
      ready = rd;
      @(posedge clk);
      m_edge(r, rd);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      req   = 3'b000;
      ready = 1'b0;
      rst   = 1'b1;
      m_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      req   = 3'b000;
      ready = 1'b0;
      #1 rst = 1'b1;
      m_reset();
      #1;
      checks++;
      if (valid !== 1'b0 || gnt !== 3'b000 || s !== 2'b10) begin
         errors++;
         $display("FAIL reset_async: valid=%b gnt=%b s=%b, need 0 000 10", valid, gnt, s);
      end
      req = 3'b111;
      ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || gnt !== 3'b000) begin
         errors++;
         $display("FAIL reset_hold: valid=%b gnt=%b, need 0 000", valid, gnt);
      end
      @(negedge clk);
      req = 3'b000;
      ready = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (valid !== 1'b0 || s !== 2'b10) begin
         errors++;
         $display("FAIL reset_release: valid=%b s=%b, need 0 10", valid, s);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] g_exp [6];
      logic [1:0] s_exp [6];
      g_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      s_exp = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
      for (int i = 0; i < 6; i++) begin
         cycle(3'b111, 1'b1);
         checks++;
         if (valid !== 1'b1 || gnt !== g_exp[i] || s !== s_exp[i]) begin
            errors++;
            $display("FAIL rr_cycle%0d: valid=%b gnt=%b s=%b, need 1 %b %b",
                     i, valid, gnt, s, g_exp[i], s_exp[i]);
         end
      end
      cycle(3'b000, 1'b1);
      checks++;
      if (valid !== 1'b0 || gnt !== 3'b000) begin
         errors++;
         $display("FAIL rr_drain: valid=%b gnt=%b, need 0 000", valid, gnt);
      end
   endtask

   task automatic test_lock();
      for (int i = 0; i < 4; i++) begin
         cycle(3'b010, 1'b0);
         checks++;
         if (valid !== 1'b1 || gnt !== 3'b010 || s !== 2'b11) begin
            errors++;
            $display("FAIL lock_cycle%0d: valid=%b gnt=%b s=%b, need 1 010 11", i, valid, gnt, s);
         end
      end
      cycle(3'b000, 1'b1);
      checks++;
      if (valid !== 1'b0 || gnt !== 3'b000 || s !== 2'b11) begin
         errors++;
         $display("FAIL lock_release: valid=%b gnt=%b s=%b, need 0 000 11", valid, gnt, s);
      end
   endtask

   task automatic test_withdraw();
      apply_reset();
      cycle(3'b100, 1'b0);
      checks++;
      if (valid !== 1'b1 || gnt !== 3'b100 || s !== 2'b00) begin
         errors++;
         $display("FAIL withdraw_grant: valid=%b gnt=%b s=%b, need 1 100 00", valid, gnt, s);
      end
      cycle(3'b000, 1'b0);
      checks++;
      if (valid !== 1'b0 || gnt !== 3'b000) begin
         errors++;
         $display("FAIL withdraw_drop: valid=%b gnt=%b, need 0 000", valid, gnt);
      end
      cycle(3'b111, 1'b0);
      checks++;
      if (valid !== 1'b1 || gnt !== 3'b001 || s !== 2'b10) begin
         errors++;
         $display("FAIL withdraw_ptr_kept: valid=%b gnt=%b s=%b, need 1 001 10", valid, gnt, s);
      end
      cycle(3'b000, 1'b1);
   endtask

   task automatic test_async_reset();
      cycle(3'b011, 1'b1);
      cycle(3'b011, 1'b0);
      #2 rst = 1'b1;
      m_reset();
      #1;
      checks++;
      if (valid !== 1'b0 || gnt !== 3'b000 || s !== 2'b10) begin
         errors++;
         $display("FAIL async_rst_midgrant: valid=%b gnt=%b s=%b, need 0 000 10", valid, gnt, s);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(3'b110, 1'b0);
      checks++;
      if (valid !== 1'b1 || gnt !== 3'b010 || s !== 2'b11) begin
         errors++;
         $display("FAIL async_rst_first: valid=%b gnt=%b s=%b, need 1 010 11", valid, gnt, s);
      end
      cycle(3'b000, 1'b1);
   endtask

   task automatic test_random();
      logic [2:0] r;
      logic [2:0] data;
      logic       rd;
      logic       y;
      bit         hs;
      int         pre_win;
      int         wcnt [3];
      r = 3'b000;
      wcnt = '{0, 0, 0};
      for (int n = 0; n < 10000; n++) begin
         rd      = ($urandom_range(0, 3) != 0);
         hs      = m_busy && rd;
         pre_win = m_win;
         if (hs) begin
            for (int k = 0; k < 3; k++) begin
               if (k != pre_win && r[k]) begin
                  wcnt[k]++;
                  checks++;
                  if (wcnt[k] > 2) begin
                     errors++;
                     $display("FAIL rand_starve: src%0d waited %0d handshakes, need <= 2", k, wcnt[k]);
                  end
               end
            end
            wcnt[pre_win] = 0;
         end
         cycle(r, rd);
         data = 3'($urandom);
         y    = mux3(data, s);
         checks++;
         if (valid !== m_busy || gnt !== m_gnt() || s !== m_s) begin
            errors++;
            $display("FAIL rand_out n=%0d: valid=%b gnt=%b s=%b, need %b %b %b",
                     n, valid, gnt, s, m_busy, m_gnt(), m_s);
         end
         checks++;
         if (s === 2'b01) begin
            errors++;
            $display("FAIL rand_sel01 n=%0d: s=%b, need not 01", n, s);
         end
         if (m_busy) begin
            checks++;
            if (y !== data[m_win]) begin
               errors++;
               $display("FAIL rand_mux n=%0d: y=%b, need %b", n, y, data[m_win]);
            end
         end
         // requesters hold until served; served ones may re-request at once
         if (hs) r[pre_win] = ($urandom_range(0, 1) == 1);
         for (int k = 0; k < 3; k++) begin
            if (!r[k]) r[k] = ($urandom_range(0, 3) == 0);
         end
      end
      cycle(3'b000, 1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      s_tab  = '{2'b10, 2'b11, 2'b00};
      m_reset();
      test_reset();
      test_round_robin();
      test_lock();
      test_withdraw();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb3s.md
ARB3S -- requirements
Module: arb3s

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 VDD, GND  input  1 each  power pins, present only when PWR_PINS is defined; no logic use.
REQ-005 req_i  input  3  per-source request; bit k = source k (data source k drives mux3s input i_i[k]).
REQ-006 ready_i  input  1  downstream consumer accepts the current mux output.
REQ-007 valid_o  output  1  mux output currently carries a granted source.
REQ-008 gnt_o  output  3  one-hot grant; all-zero when valid_o=0.
REQ-009 s_o  output  2  select code driving mux3s s_i directly.

Function
REQ-010 All outputs SHALL be driven from registers; no combinational path from any input to any output.
REQ-011 Select encoding SHALL be: source 0 -> s_o=2'b10, source 1 -> s_o=2'b11, source 2 -> s_o=2'b00; code 2'b01 SHALL never be driven.
REQ-012 State machine SHALL have two states, IDLE and GRANT; IDLE implies valid_o=0 and gnt_o=3'b000; GRANT implies valid_o=1 and gnt_o one-hot.
REQ-013 A 2-bit round-robin pointer ptr (range 0..2, last-served source) SHALL select priority order ptr+1, ptr+2, ptr+3 modulo 3.
REQ-014 IDLE: if req_i != 0 at a clock edge, SHALL register the highest-priority requester as winner, set gnt_o/s_o for it and enter GRANT; latency from req_i rise to valid_o = 1 cycle.
REQ-015 IDLE with req_i == 0: SHALL remain IDLE; s_o SHALL hold its previous value; ptr unchanged.
REQ-016 GRANT: grant SHALL remain locked (gnt_o, s_o stable) while ready_i=0 and req_i[winner]=1.
REQ-017 Handshake = valid_o & ready_i at an edge; on handshake ptr SHALL load the winner index.
REQ-018 On handshake, if any req_i bit other than the winner is set, the next winner SHALL be chosen with the updated ptr and GRANT kept (back-to-back, no bubble).
REQ-019 On handshake with only the winner requesting, the winner SHALL be re-granted (stay GRANT); with req_i == 0, SHALL return to IDLE.
REQ-020 In GRANT, if req_i[winner] drops without handshake, SHALL return to IDLE on that edge, ptr unchanged (withdrawn request, no transfer).
REQ-021 Fairness: with all three requesting continuously and ready_i=1, grant order SHALL be strictly cyclic 0,1,2,0,... with no source granted twice within any 3 consecutive handshakes.
REQ-022 Pointer wrap: ptr=2 SHALL give priority order 0,1,2.
REQ-023 Requester protocol: source k completes when gnt_o[k] & ready_i; sources SHALL hold req_i until then (block tolerates violation per REQ-020).

Reset
REQ-024 Asserting rst_i SHALL immediately, without clock, force: state IDLE, valid_o=0, gnt_o=3'b000, s_o=2'b10, ptr=2.
REQ-025 Reset asserted mid-GRANT SHALL abandon the grant with no handshake recorded; first grant after release SHALL follow ptr=2 (source 0 first).
REQ-026 Deassertion of rst_i SHALL take effect at the next rising edge; first grant possible on the edge after release.

Verification
REQ-027 Reset, then req_i=3'b111, ready_i=1 for 6 cycles -> valid_o high from cycle 1; gnt_o sequence 001,010,100,001,010,100; s_o sequence 10,11,00,10,11,00.
REQ-028 req_i=3'b010, ready_i=0 for 4 cycles, then ready_i=1 for 1 cycle with req_i=3'b000 -> gnt_o=010, s_o=11 stable all 4 cycles; IDLE, valid_o=0 next cycle.
REQ-029 Grant source 2 with ready_i=0, then req_i[2] drops -> valid_o=0, gnt_o=000 next edge; subsequent req_i=3'b111 -> source 0 granted (ptr unchanged from before).
REQ-030 Assert rst_i asynchronously mid-GRANT between edges -> valid_o=0, gnt_o=000, s_o=10 before next edge; after release req_i=3'b110 -> source 1 granted first.
REQ-031 Random req_i/ready_i for 10000 cycles with a mux3s instance and reference model -> y_o equals i_i[winner] whenever valid_o=1; s_o never 2'b01; every held request served within 3 handshakes.
